instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Front end of the CPU pipeline. Holds the program counter and fetches 32-bit instructions from instruction memory over a req/ack interface.
- Presents each fetched `Instruction` and its `Address` to the decode stage with a valid/ready handshake.
- Consumes the decode stage's branch resolution (`PCSrc`, `BranchAddress`): redirects the PC and discards any wrong-path instruction.

Parameters:
- RESET_PC, 64'h0: PC value loaded at reset.
- PC_STEP, 4: sequential PC increment in bytes.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- PCSrc  in  1  branch taken; sampled on each rising edge.
- BranchAddress  in  64  redirect target; valid when PCSrc=1.
- imem_req  out  1  instruction memory request.
- imem_addr  out  64  request address.
- imem_ack  in  1  memory response; imem_rdata valid this cycle; only asserted while imem_req=1.
- imem_rdata  in  32  returned instruction word.
- Instruction  out  32  instruction to decode.
- Address  out  64  byte address of Instruction.
- instr_valid  out  1  Instruction/Address valid.
- decode_ready  in  1  decode accepts the instruction this cycle.

Behaviour:
- Reset (reset_n=0, immediate, asynchronous):
  - pc=RESET_PC, state=IDLE.
  - imem_req=0, imem_addr=0, Instruction=0, Address=0, instr_valid=0.
  - Any in-flight memory request is abandoned; the memory must drop it.
- All outputs are registered.
- imem_req and imem_addr are stable from assertion until the cycle imem_ack=1.
- FSM states: IDLE, FETCH, HOLD, KILL.
- IDLE:
  - Always → FETCH next cycle, with imem_req=1 and imem_addr=pc.
  - If PCSrc=1: pc<=BranchAddress, and the first request goes to BranchAddress.
- FETCH (imem_req=1, imem_addr=pc):
  - imem_ack=1 and PCSrc=0: Instruction<=imem_rdata, Address<=pc, instr_valid<=1, pc<=pc+PC_STEP, imem_req<=0 → HOLD.
  - imem_ack=1 and PCSrc=1: discard imem_rdata; pc<=BranchAddress; imem_addr<=BranchAddress, req stays 1 → FETCH.
  - imem_ack=0 and PCSrc=1: pc<=BranchAddress; req/addr held at old address → KILL.
  - imem_ack=0 and PCSrc=0: hold.
- HOLD (imem_req=0, instr_valid=1):
  - PCSrc=1: instr_valid<=0, pc<=BranchAddress → FETCH at BranchAddress. Flush takes priority over decode_ready.
  - decode_ready=1: instr_valid<=0 → FETCH at pc.
  - Otherwise: Instruction, Address and pc held unchanged.
- KILL (req held at old address until ack; result is discarded):
  - PCSrc=1 again: pc<=BranchAddress, stay KILL (last redirect wins).
  - imem_ack=1: data dropped, instr_valid stays 0 → FETCH at pc, issuing imem_addr<=pc the same edge.
- Timing:
  - Minimum turnaround with a zero-wait memory (ack in first req cycle) is 1 instruction per 2 cycles; a long stall in HOLD adds no other penalty.
  - Instruction appears the cycle after ack.
- Arithmetic and addresses:
  - pc+PC_STEP wraps modulo 2^64.
  - BranchAddress is loaded as-is; no alignment check is performed.
- A wrong-path instruction never has instr_valid=1 after the edge that sampled PCSrc=1.

Test Plan:
1. Release reset, memory acks 1 cycle after req with 32'h8B020020 → imem_addr=0. Next cycle: Instruction=32'h8B020020, Address=0, instr_valid=1. After decode_ready=1: imem_addr=4.
2. Hold decode_ready=0 for 3 cycles in HOLD → Instruction/Address unchanged, imem_req=0. Then ready=1 → instr_valid=0 next cycle, request at 4.
3. In HOLD with Address=4, drive PCSrc=1, BranchAddress=64'h100, decode_ready=1 → instr_valid=0, next request at 64'h100. Instruction at 8 never issued.
4. Request at 8 outstanding, PCSrc=1, BranchAddress=64'h200, ack delayed 3 cycles:
   - imem_addr stays 8 until ack.
   - Returned data never shown (instr_valid=0).
   - Next request at 64'h200.
   - A second redirect to 64'h300 during KILL → next request at 64'h300.
5. PCSrc=1 (target 64'h40) in the same cycle as ack at 12 → data discarded, imem_req stays 1 with imem_addr=64'h40 next cycle.
6. Two checks:
   - RESET_PC=64'hFFFF_FFFF_FFFF_FFFC: after first fetch, next imem_addr=0.
   - Assert reset_n=0 mid-FETCH between edges: all outputs zero immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction memory req/ack, decode valid/ready, and
// the branch redirect coming back from decode.
interface instruction_fetch_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction;
    logic [63:0] Address;
    logic        instr_valid;
    logic        decode_ready;
    logic        PCSrc;
    logic [63:0] BranchAddress;

    modport master (
        output imem_req, imem_addr, Instruction, Address, instr_valid,
        input  imem_ack, imem_rdata, decode_ready, PCSrc, BranchAddress
    );

    modport slave (
        input  imem_req, imem_addr, Instruction, Address, instr_valid,
        output imem_ack, imem_rdata, decode_ready, PCSrc, BranchAddress
    );
endinterface

// File: rtl/instruction_fetch.sv
// Pipeline front end: owns the PC, fetches one word at a time from instruction
// memory and hands it to decode, redirecting on branch resolution.
//
// state | meaning
// IDLE  | out of reset, first request issued next edge
// FETCH | request outstanding at imem_addr (== pc)
// HOLD  | instruction presented to decode, waiting for ready
// KILL  | redirected while a request was outstanding; drain and drop its data
module instruction_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    instruction_fetch_if.master          bus
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, KILL} state_t;

    state_t      state;
    logic [63:0] pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            pc              <= RESET_PC;
            bus.imem_req    <= 1'b0;
            bus.imem_addr   <= 64'h0;
            bus.Instruction <= 32'h0;
            bus.Address     <= 64'h0;
            bus.instr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state        <= FETCH;
                    bus.imem_req <= 1'b1;
                    if (bus.PCSrc) begin
                        pc            <= bus.BranchAddress;
                        bus.imem_addr <= bus.BranchAddress;
                    end else begin
                        bus.imem_addr <= pc;
                    end
                end
                FETCH: begin
                    if (bus.imem_ack) begin
                        if (bus.PCSrc) begin
                            // Wrong-path data: re-issue at the target without dropping req.
                            pc            <= bus.BranchAddress;
                            bus.imem_addr <= bus.BranchAddress;
                        end else begin
                            bus.Instruction <= bus.imem_rdata;
                            bus.Address     <= pc;
                            bus.instr_valid <= 1'b1;
                            pc              <= pc + 64'(PC_STEP);
                            bus.imem_req    <= 1'b0;
                            state           <= HOLD;
                        end
                    end else if (bus.PCSrc) begin
                        // Memory must see a stable request until it acks.
                        pc    <= bus.BranchAddress;
                        state <= KILL;
                    end
                end
                HOLD: begin
                    if (bus.PCSrc) begin
                        pc              <= bus.BranchAddress;
                        bus.instr_valid <= 1'b0;
                        bus.imem_req    <= 1'b1;
                        bus.imem_addr   <= bus.BranchAddress;
                        state           <= FETCH;
                    end else if (bus.decode_ready) begin
                        bus.instr_valid <= 1'b0;
                        bus.imem_req    <= 1'b1;
                        bus.imem_addr   <= pc;
                        state           <= FETCH;
                    end
                end
                KILL: begin
                    if (bus.imem_ack) begin
                        state <= FETCH;
                        if (bus.PCSrc) begin
                            pc            <= bus.BranchAddress;
                            bus.imem_addr <= bus.BranchAddress;
                        end else begin
                            bus.imem_addr <= pc;
                        end
                    end else if (bus.PCSrc) begin
                        pc <= bus.BranchAddress;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: scoreboard of expected decode-side
// words plus point checks on the memory request bus.
module tb_instruction_fetch;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_if if0 ();
    instruction_fetch_if if1 ();

    instruction_fetch #(.RESET_PC(64'h0), .PC_STEP(4)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(if0.master)
    );
    instruction_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .PC_STEP(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(if1.master)
    );

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    logic prev_valid = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Every new presentation to decode must match the next expected word.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_valid = 1'b0;
        end else begin
            if (if0.instr_valid === 1'b1 && prev_valid !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", {32'h0, if0.Instruction}, 64'h0);
                    chk("spurious_valid_flag", 64'(if0.instr_valid), 64'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_instruction", {32'h0, if0.Instruction}, {32'h0, e.data});
                    chk("sb_address", if0.Address, e.addr);
                end
            end
            prev_valid = if0.instr_valid;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        if0.imem_ack = 0; if0.imem_rdata = 0; if0.decode_ready = 0;
        if0.PCSrc = 0; if0.BranchAddress = 0;
        if1.imem_ack = 0; if1.imem_rdata = 0; if1.decode_ready = 0;
        if1.PCSrc = 0; if1.BranchAddress = 0;

        #1 reset_n = 1'b0;
        #1;
        chk("rst_req", 64'(if0.imem_req), 64'h0);
        chk("rst_addr", if0.imem_addr, 64'h0);
        chk("rst_instr", {32'h0, if0.Instruction}, 64'h0);
        chk("rst_address", if0.Address, 64'h0);
        chk("rst_valid", 64'(if0.instr_valid), 64'h0);
        chk("rst1_addr", if1.imem_addr, 64'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        chk("first_req", 64'(if0.imem_req), 64'h1);
        chk("first_addr", if0.imem_addr, 64'h0);
        chk("wrap_first_addr", if1.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);

        // PC wrap on the second instance while dut0 waits with no ack.
        if1.imem_ack = 1; if1.imem_rdata = 32'h1234_5678;
        tick();
        if1.imem_ack = 0;
        chk("wrap_valid", 64'(if1.instr_valid), 64'h1);
        chk("wrap_address", if1.Address, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_instr", {32'h0, if1.Instruction}, 64'h1234_5678);
        if1.decode_ready = 1;
        tick();
        if1.decode_ready = 0;
        chk("wrap_next_req", 64'(if1.imem_req), 64'h1);
        chk("wrap_next_addr", if1.imem_addr, 64'h0);
        chk("wait_addr_stable", if0.imem_addr, 64'h0);
        chk("wait_req_stable", 64'(if0.imem_req), 64'h1);

        // Ack at 0, then stall decode for three cycles.
        if0.imem_ack = 1; if0.imem_rdata = 32'h8B02_0020;
        push(64'h0, 32'h8B02_0020);
        tick();
        if0.imem_ack = 0; if0.imem_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", 64'(if0.instr_valid), 64'h1);
            chk("hold_instr", {32'h0, if0.Instruction}, 64'h8B02_0020);
            chk("hold_address", if0.Address, 64'h0);
            chk("hold_req", 64'(if0.imem_req), 64'h0);
            tick();
        end
        if0.decode_ready = 1;
        tick();
        if0.decode_ready = 0;
        chk("accept_valid", 64'(if0.instr_valid), 64'h0);
        chk("accept_req", 64'(if0.imem_req), 64'h1);
        chk("accept_addr", if0.imem_addr, 64'h4);

        // Zero-wait fetch at 4, then flush from HOLD with ready also high.
        if0.imem_ack = 1; if0.imem_rdata = 32'hAAAA_0004;
        push(64'h4, 32'hAAAA_0004);
        tick();
        if0.imem_ack = 0;
        chk("hold4_address", if0.Address, 64'h4);
        if0.PCSrc = 1; if0.BranchAddress = 64'h100; if0.decode_ready = 1;
        tick();
        if0.PCSrc = 0; if0.decode_ready = 0;
        chk("flush_valid", 64'(if0.instr_valid), 64'h0);
        chk("flush_req", 64'(if0.imem_req), 64'h1);
        chk("flush_addr", if0.imem_addr, 64'h100);
        if0.imem_ack = 1; if0.imem_rdata = 32'hAAAA_0100;
        push(64'h100, 32'hAAAA_0100);
        tick();
        if0.imem_ack = 0;
        if0.decode_ready = 1;
        tick();
        if0.decode_ready = 0;
        chk("seq_addr", if0.imem_addr, 64'h104);

        // Redirect while 0x104 is outstanding, second redirect during KILL.
        if0.PCSrc = 1; if0.BranchAddress = 64'h200;
        tick();
        if0.PCSrc = 0;
        chk("kill_addr_held", if0.imem_addr, 64'h104);
        chk("kill_req_held", 64'(if0.imem_req), 64'h1);
        tick();
        chk("kill_addr_held2", if0.imem_addr, 64'h104);
        if0.PCSrc = 1; if0.BranchAddress = 64'h300;
        tick();
        if0.PCSrc = 0;
        chk("kill_addr_held3", if0.imem_addr, 64'h104);
        if0.imem_ack = 1; if0.imem_rdata = 32'hDEAD_DEAD;
        tick();
        if0.imem_ack = 0;
        chk("kill_drop_valid", 64'(if0.instr_valid), 64'h0);
        chk("kill_next_req", 64'(if0.imem_req), 64'h1);
        chk("kill_next_addr", if0.imem_addr, 64'h300);

        // Redirect coinciding with ack.
        if0.imem_ack = 1; if0.imem_rdata = 32'hBAD0_0300;
        if0.PCSrc = 1; if0.BranchAddress = 64'h40;
        tick();
        if0.imem_ack = 0; if0.PCSrc = 0;
        chk("ackbr_valid", 64'(if0.instr_valid), 64'h0);
        chk("ackbr_req", 64'(if0.imem_req), 64'h1);
        chk("ackbr_addr", if0.imem_addr, 64'h40);
        if0.imem_ack = 1; if0.imem_rdata = 32'hAAAA_0040;
        push(64'h40, 32'hAAAA_0040);
        tick();
        if0.imem_ack = 0;
        chk("ackbr_address", if0.Address, 64'h40);
        if0.decode_ready = 1;
        tick();
        if0.decode_ready = 0;
        chk("pre_rst_addr", if0.imem_addr, 64'h44);

        // Asynchronous reset between edges while fetching.
        #2 reset_n = 1'b0;
        #1;
        chk("async_req", 64'(if0.imem_req), 64'h0);
        chk("async_addr", if0.imem_addr, 64'h0);
        chk("async_valid", 64'(if0.instr_valid), 64'h0);
        chk("async_instr", {32'h0, if0.Instruction}, 64'h0);
        chk("async_address", if0.Address, 64'h0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("restart_req", 64'(if0.imem_req), 64'h1);
        chk("restart_addr", if0.imem_addr, 64'h0);
        chk("restart1_addr", if1.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        if0.imem_ack = 1; if0.imem_rdata = 32'h5555_0000;
        push(64'h0, 32'h5555_0000);
        tick();
        if0.imem_ack = 0;
        tick();
        chk("sb_drained", 64'(exp_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
